serial_tree_reducer: RTL and testbench



---
 rtl/serial_tree_reducer.sv | 63 ++++++
 tb/tb_serial_tree_reducer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tree_reducer.sv
// serial_tree_reducer: accumulates up to MAX_OPS serially streamed N-bit operands into an exact N+3-bit sum.
module serial_tree_reducer #(
    parameter int N       = 64,
    parameter int MAX_OPS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+2:0] out_sum,
    output logic [3:0]   out_count,
    output logic         out_cout
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t       state_q;
    logic [N+2:0] acc_q;
    logic [3:0]   cnt_q;
    logic         cout_q, in_ready_q, out_valid_q;
    logic [N+3:0] sum_d;
    logic [3:0]   cnt_d;
    logic         in_fire, out_fire, term_d;
    always_comb begin
        in_fire  = in_valid && in_ready_q;
        out_fire = out_valid_q && out_ready;
        sum_d    = (state_q == IDLE ? '0 : {1'b0, acc_q}) + {4'b0, in_data};
        cnt_d    = state_q == IDLE ? 4'd1 : cnt_q + 4'd1;
        term_d   = in_last || cnt_d == 4'(MAX_OPS);
    end
    // in_ready/out_valid are mutually exclusive flags that track DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            acc_q       <= sum_d[N+2:0];
            cout_q      <= sum_d[N+3];
            cnt_q       <= cnt_d;
            state_q     <= term_d ? DONE : ACCUM;
            in_ready_q  <= !term_d;
            out_valid_q <= term_d;
        end else if (out_fire) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_cout  = cout_q;
endmodule

// File: tb/tb_serial_tree_reducer.sv
// tb_serial_tree_reducer: randomized stream driver with a queue-based group model and a decoupled output monitor.
module tb_serial_tree_reducer;
    localparam int N = 64;
    localparam int MAXOPS = 8;
    typedef struct {logic [N+2:0] s; logic [3:0] c;} exp_t;

    logic clk, rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_cout;
    logic [N-1:0] in_data;
    logic [N+2:0] out_sum;
    logic [3:0] out_count;

    exp_t exp_q[$];
    logic [N-1:0] grp[$];
    int checks = 0, errors = 0;
    bit hold = 0, rbp = 0;

    serial_tree_reducer #(.N(N), .MAX_OPS(MAXOPS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_cout(out_cout));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [N+3:0] act, input logic [N+3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // out_ready driver: forced low under hold, random under rbp, else high
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : (rbp ? 1'($urandom % 2) : 1'b1);
        end
    end

    task automatic idle(input int n);
        in_valid = 0;
        in_data = {$urandom, $urandom};
        in_last = 1'($urandom % 2);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [N-1:0] d, input bit l);
        int t = 0;
        logic [N+2:0] s;
        in_valid = 1;
        in_data = d;
        in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++t > 1000) begin
                chk("in_ready_timeout", 0, 1);
                idle(0);
                return;
            end
        end
        @(posedge clk);
        #1;
        idle(0);
        grp.push_back(d);
        if (l || grp.size() == MAXOPS) begin
            s = '0;
            foreach (grp[i]) s += (N+3)'(grp[i]);
            exp_q.push_back('{s, 4'(grp.size())});
            grp.delete();
            chk("latency", out_valid, 1);
        end
    endtask

    initial begin
        bit prev_fire = 0, held = 0;
        logic [N+2:0] hs;
        logic [3:0] hc;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fire = 0;
                held = 0;
                continue;
            end
            chk("ready_excl", in_ready, !out_valid);
            if (prev_fire) chk("ready_after_hs", in_ready, 1);
            if (out_valid) begin
                if (held) begin
                    chk("stable_sum", out_sum, hs);
                    chk("stable_count", out_count, hc);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sum", out_sum, e.s);
                        chk("count", out_count, e.c);
                        chk("cout", out_cout, 0);
                    end
                end
                held = !out_ready;
                hs = out_sum;
                hc = out_count;
            end else held = 0;
            prev_fire = out_valid && out_ready;
        end
    end

    initial begin
        int t;
        rst_n = 0;
        idle(0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_cout", out_cout, 0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 1; i <= 8; i++) beat(N'(i), 0);
        beat(10, 0);
        beat(20, 0);
        beat(30, 1);
        for (int i = 0; i < 8; i++) beat('1, 0);
        hold = 1;
        for (int i = 0; i < 8; i++) beat({$urandom, $urandom}, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        hold = 0;
        for (int i = 0; i < 8; i++) begin
            beat(N'('h100), 0);
            idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 4; i++) beat(5, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sum", out_sum, 0);
        chk("arst_count", out_count, 0);
        grp.delete();
        @(posedge clk);
        #1 rst_n = 1;
        beat(1, 0);
        beat(1, 1);
        rbp = 1;
        for (int g = 0; g < 25; g++) begin
            int len = $urandom_range(1, 8);
            for (int i = 1; i <= len; i++) begin
                beat({$urandom, $urandom}, i == len ? (len < 8 ? 1'b1 : 1'($urandom % 2)) : 1'b0);
                idle($urandom_range(0, 2));
            end
        end
        rbp = 0;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
